// File: rtl/uart_tx_frame_if.sv
// Payload handshake between the packet/formatter logic and the UART transmitter.
// The source offers a payload plus its parity mode; the transmitter answers
// with din_ready while its one-entry holding register is empty.
interface uart_tx_frame_if #(
  parameter int DBIT = 8
);
  logic [DBIT-1:0] din;
  logic            din_valid;
  logic            din_ready;
  logic [1:0]      par_mode;

  modport master (
    output din,
    output din_valid,
    output par_mode,
    input  din_ready
  );

  modport slave (
    input  din,
    input  din_valid,
    input  par_mode,
    output din_ready
  );
endinterface

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: DBIT data bits LSB first, optional parity
// (none/even/odd/mark selected per frame), SB_TICK-tick stop period.
// A one-entry holding register lets the next frame start on the same edge
// the previous one finishes, so back-to-back frames have no idle gap.
module uart_tx_frame #(
  parameter int DBIT    = 8,
  parameter int OVS     = 16,
  parameter int SB_TICK = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           s_tick,
  uart_tx_frame_if.slave bus,
  output logic           tx,
  output logic           tx_busy,
  output logic           tx_done_tick
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [5:0] S_LAST  = 6'(OVS - 1);
  localparam logic [5:0] SB_LAST = 6'(SB_TICK - 1);
  localparam logic [3:0] N_LAST  = 4'(DBIT - 1);

  state_t          state_reg, state_next;
  logic [5:0]      s_reg, s_next;
  logic [3:0]      n_reg, n_next;
  logic [DBIT-1:0] shift_reg, shift_next;
  logic            par_reg, par_next;
  logic [1:0]      mode_reg, mode_next;
  logic            tx_reg, tx_next;
  logic            done_reg, done_next;

  logic [DBIT-1:0] hold_data_reg;
  logic [1:0]      hold_mode_reg;
  logic            hold_full_reg;

  logic            load;
  logic            accept;

  // Accept only into an empty holding register; the load empties it.
  assign accept = bus.din_valid && !hold_full_reg;

  // Holding register: latch payload and parity mode on a handshake, free it on load.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_full_reg <= 1'b0;
      hold_data_reg <= '0;
      hold_mode_reg <= 2'b00;
    end else if (load) begin
      hold_full_reg <= 1'b0;
    end else if (accept) begin
      hold_full_reg <= 1'b1;
      hold_data_reg <= bus.din;
      hold_mode_reg <= bus.par_mode;
    end
  end

  // Frame state, counters, shifter and the registered line level.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      shift_reg <= '0;
      par_reg   <= 1'b0;
      mode_reg  <= 2'b00;
      tx_reg    <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      shift_reg <= shift_next;
      par_reg   <= par_next;
      mode_reg  <= mode_next;
      tx_reg    <= tx_next;
      done_reg  <= done_next;
    end
  end

  // Next-state logic; tx_next is derived from the state being entered so the
  // line changes on the same edge as the state.
  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    shift_next = shift_reg;
    par_next   = par_reg;
    mode_next  = mode_reg;
    done_next  = 1'b0;
    load       = 1'b0;
    tx_next    = 1'b1;

    case (state_reg)
      IDLE: begin
        if (hold_full_reg) load = 1'b1;
      end
      START: begin
        if (s_tick) begin
          if (s_reg == S_LAST) begin
            state_next = DATA;
            s_next     = '0;
            n_next     = '0;
          end else begin
            s_next = s_reg + 6'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_reg == S_LAST) begin
            s_next     = '0;
            shift_next = shift_reg >> 1;
            par_next   = par_reg ^ shift_reg[0];
            if (n_reg == N_LAST) begin
              state_next = (mode_reg == 2'b00) ? STOP : PARITY;
            end else begin
              n_next = n_reg + 4'd1;
            end
          end else begin
            s_next = s_reg + 6'd1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s_reg == S_LAST) begin
            state_next = STOP;
            s_next     = '0;
          end else begin
            s_next = s_reg + 6'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_reg == SB_LAST) begin
            done_next = 1'b1;
            s_next    = '0;
            if (hold_full_reg) load = 1'b1;
            else state_next = IDLE;
          end else begin
            s_next = s_reg + 6'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Load overrides: frame parameters are captured here and stay fixed for the frame.
    if (load) begin
      state_next = START;
      s_next     = '0;
      n_next     = '0;
      shift_next = hold_data_reg;
      mode_next  = hold_mode_reg;
      par_next   = 1'b0;
    end

    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = (mode_next == 2'b11) ? 1'b1 :
                         (mode_next == 2'b10) ? ~par_next : par_next;
      default: tx_next = 1'b1;
    endcase
  end

  assign tx            = tx_reg;
  assign tx_busy       = (state_reg != IDLE);
  assign tx_done_tick  = done_reg;
  assign bus.din_ready = ~hold_full_reg;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: two instances (8-bit/1 stop and 7-bit/2 stop).
// Stimulus pushes the expected line pattern of each frame into a queue; a
// monitor per instance samples tx at every consumed s_tick and compares the
// whole frame when tx_done_tick fires.
`timescale 1ns/1ps
module tb_uart_tx_frame;

  typedef struct {
    logic [11:0] bits;  // line level per bit slot: start, data LSB first, parity
    int          nb;    // number of OVS-long bit slots
    int          ovs;
    int          sb;
    logic        b2b;   // another frame starts on the done edge
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic s_tick = 1'b0;
  int   tick_div = 1;
  logic tx0, busy0, done0, tx1, busy1, done1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q0[$];
  exp_t exp_q1[$];

  uart_tx_frame_if #(.DBIT(8)) bus0 ();
  uart_tx_frame_if #(.DBIT(7)) bus1 ();

  uart_tx_frame #(.DBIT(8), .OVS(16), .SB_TICK(16)) dut0 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .bus(bus0),
    .tx(tx0), .tx_busy(busy0), .tx_done_tick(done0)
  );

  uart_tx_frame #(.DBIT(7), .OVS(16), .SB_TICK(32)) dut1 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .bus(bus1),
    .tx(tx1), .tx_busy(busy1), .tx_done_tick(done1)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input int i);
    return (i == 0) ? bus0.din_ready : bus1.din_ready;
  endfunction

  function automatic logic busy(input int i);
    return (i == 0) ? busy0 : busy1;
  endfunction

  task automatic set_in(input int i, input logic [8:0] d, input logic [1:0] m, input logic v);
    if (i == 0) begin
      bus0.din = d[7:0]; bus0.par_mode = m; bus0.din_valid = v;
    end else begin
      bus1.din = d[6:0]; bus1.par_mode = m; bus1.din_valid = v;
    end
  endtask

  // Expected frame; par is the hand-computed parity bit (ignored for mode 00).
  task automatic push_exp(input int i, input logic [8:0] d, input logic [1:0] m,
                          input logic par, input logic b2b);
    exp_t e;
    int   db;
    db = (i == 0) ? 8 : 7;
    e.bits = '0;
    for (int j = 0; j < db; j++) e.bits[1 + j] = d[j];
    e.nb = 1 + db;
    if (m != 2'b00) begin
      e.bits[e.nb] = par;
      e.nb++;
    end
    e.ovs = 16;
    e.sb  = (i == 0) ? 16 : 32;
    e.b2b = b2b;
    if (i == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
  endtask

  // Offer a payload and return just after the accepting edge.
  task automatic offer(input int i, input logic [8:0] d, input logic [1:0] m, input logic keep);
    logic r;
    r = 1'b0;
    set_in(i, d, m, 1'b1);
    for (int k = 0; k < 5000; k++) begin
      r = rdy(i);
      cyc();
      if (r) break;
    end
    chk($sformatf("dut%0d_accept", i), r, 1);
    if (!keep) set_in(i, d, m, 1'b0);
  endtask

  task automatic wait_idle(input int i);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      if (!busy(i) && rdy(i)) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    chk($sformatf("dut%0d_idle_reached", i), ok, 1);
  endtask

  // s_tick every tick_div cycles, changed just after the rising edge.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_div <= 1) begin
        s_tick = 1'b1;
      end else begin
        cnt    = (cnt + 1) % tick_div;
        s_tick = (cnt == 0);
      end
    end
  end

  // Frame monitors: collect tx at each tick consumed by a busy transmitter.
  for (genvar gi = 0; gi < 2; gi++) begin : g_mon
    logic m_tx, m_busy, m_done;
    assign m_tx   = (gi == 0) ? tx0 : tx1;
    assign m_busy = (gi == 0) ? busy0 : busy1;
    assign m_done = (gi == 0) ? done0 : done1;

    logic samp_q[$];

    initial begin
      exp_t e;
      int   qs;
      int   bad;
      logic lvl;
      logic got;
      forever begin
        @(negedge clk);
        if (reset) begin
          samp_q.delete();
        end else begin
          if (m_done) begin
            qs = (gi == 0) ? exp_q0.size() : exp_q1.size();
            if (qs == 0) begin
              checks++;
              errors++;
              $display("FAIL dut%0d_unexpected_frame: got a frame of %0d ticks expected none",
                       gi, samp_q.size());
            end else begin
              if (gi == 0) e = exp_q0.pop_front();
              else e = exp_q1.pop_front();
              chk($sformatf("dut%0d_frame_ticks", gi), samp_q.size(), e.ovs * e.nb + e.sb);
              bad = -1;
              lvl = 1'b1;
              got = 1'b1;
              for (int j = 0; j < samp_q.size() && j < e.ovs * e.nb + e.sb; j++) begin
                lvl = (j < e.ovs * e.nb) ? e.bits[j / e.ovs] : 1'b1;
                if (samp_q[j] !== lvl) begin
                  bad = j;
                  got = samp_q[j];
                  break;
                end
              end
              checks++;
              if (bad >= 0) begin
                errors++;
                $display("FAIL dut%0d_frame_bits: tick %0d got %b expected %b", gi, bad, got, lvl);
              end
              chk($sformatf("dut%0d_done_tx", gi), m_tx, !e.b2b);
              chk($sformatf("dut%0d_done_busy", gi), m_busy, e.b2b);
              $display("dut%0d frame: %0d ticks, %0d bit slots, b2b=%0b", gi, samp_q.size(), e.nb, e.b2b);
            end
            samp_q.delete();
          end
          if (m_busy && s_tick) samp_q.push_back(m_tx);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   tt[4];
    int   n;
    int   seen;
    logic prev;
    logic bad;

    set_in(0, 9'h0, 2'b00, 1'b0);
    set_in(1, 9'h0, 2'b00, 1'b0);
    repeat (3) cyc();
    chk("reset_tx0", tx0, 1);
    chk("reset_busy0", busy0, 0);
    chk("reset_done0", done0, 0);
    chk("reset_ready0", bus0.din_ready, 1);
    chk("reset_tx1", tx1, 1);
    chk("reset_ready1", bus1.din_ready, 1);
    reset = 1'b0;
    cyc();

    // 8N1 0x55 with handshake/load latency
    push_exp(0, 9'h055, 2'b00, 1'b0, 1'b0);
    offer(0, 9'h055, 2'b00, 1'b0);
    chk("e0_ready_low", bus0.din_ready, 0);
    chk("e0_tx_idle", tx0, 1);
    cyc();
    chk("e1_tx_start", tx0, 0);
    chk("e1_ready_high", bus0.din_ready, 1);
    chk("e1_busy", busy0, 1);
    wait_idle(0);

    // DBIT=7, SB_TICK=32, parity modes
    push_exp(1, 9'h003, 2'b01, 1'b0, 1'b0); offer(1, 9'h003, 2'b01, 1'b0); wait_idle(1);
    push_exp(1, 9'h003, 2'b10, 1'b1, 1'b0); offer(1, 9'h003, 2'b10, 1'b0); wait_idle(1);
    push_exp(1, 9'h003, 2'b11, 1'b1, 1'b0); offer(1, 9'h003, 2'b11, 1'b0); wait_idle(1);
    push_exp(1, 9'h007, 2'b01, 1'b1, 1'b0); offer(1, 9'h007, 2'b01, 1'b0); wait_idle(1);
    push_exp(1, 9'h007, 2'b10, 1'b0, 1'b0); offer(1, 9'h007, 2'b10, 1'b0); wait_idle(1);

    // back-to-back with din_valid held high
    push_exp(0, 9'h03C, 2'b01, 1'b0, 1'b1);
    push_exp(0, 9'h0C1, 2'b10, 1'b0, 1'b0);
    offer(0, 9'h03C, 2'b01, 1'b1);
    offer(0, 9'h0C1, 2'b10, 1'b0);
    chk("b2b_accept_in_frame1", busy0, 1);
    bad = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      if (done0) break;
      if (bus0.din_ready) bad = 1'b1;
      cyc();
    end
    chk("b2b_ready_low_until_load", bad, 0);
    chk("b2b_done_seen", done0, 1);
    chk("b2b_ready_at_load", bus0.din_ready, 1);
    chk("b2b_tx_start_at_done", tx0, 0);
    wait_idle(0);

    // s_tick every 3rd cycle: bits are 48 cycles wide
    tick_div = 3;
    push_exp(0, 9'h00F, 2'b11, 1'b1, 1'b0);
    offer(0, 9'h00F, 2'b11, 1'b0);
    n = 0;
    tt = '{0, 0, 0, 0};
    prev = tx0;
    for (int k = 0; k < 3000 && n < 4; k++) begin
      cyc();
      if (tx0 !== prev) begin
        tt[n] = k;
        n++;
        prev = tx0;
      end
    end
    chk("div3_edges", n, 4);
    chk("div3_bits0to3_cycles", tt[2] - tt[1], 192);
    chk("div3_bits4to7_cycles", tt[3] - tt[2], 192);
    wait_idle(0);
    tick_div = 1;
    repeat (3) cyc();

    // reset in the middle of DATA with a byte held
    offer(0, 9'h099, 2'b00, 1'b0);
    offer(0, 9'h066, 2'b01, 1'b0);
    repeat (60) cyc();
    chk("pre_reset_held", bus0.din_ready, 0);
    reset = 1'b1;
    cyc();
    chk("midreset_tx", tx0, 1);
    chk("midreset_busy", busy0, 0);
    chk("midreset_ready", bus0.din_ready, 1);
    chk("midreset_done", done0, 0);
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 500; k++) begin
      cyc();
      if (busy0 || done0) seen++;
    end
    chk("after_reset_silent", seen, 0);

    // par_mode toggles and din_valid held while full
    push_exp(0, 9'h081, 2'b01, 1'b0, 1'b1);
    push_exp(0, 9'h07E, 2'b00, 1'b0, 1'b0);
    offer(0, 9'h081, 2'b01, 1'b0);
    offer(0, 9'h07E, 2'b00, 1'b0);
    set_in(0, 9'h0FF, 2'b01, 1'b1);
    bad = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (bus0.din_ready) bad = 1'b1;
      bus0.par_mode = bus0.par_mode + 2'b01;
      cyc();
    end
    set_in(0, 9'h0FF, 2'b00, 1'b0);
    chk("full_no_accept", bad, 0);
    for (int k = 0; k < 2000 && !done0; k++) cyc();
    chk("toggle_frame1_done", done0, 1);
    cyc();
    wait_idle(0);

    repeat (5) cyc();
    chk("dut0_all_frames_seen", exp_q0.size(), 0);
    chk("dut1_all_frames_seen", exp_q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
